led_blink_pwm_driver: RTL

Output stage between the LED PIO register and the board LED pins. It takes the static 4-bit pattern the CPU writes to the PIO and adds three things before driving the pins: per-LED blink, per-LED activity stretching for Ethernet RX/TX/link events, and global PWM dimming. Everything runs on the PIO's system clock; all outputs are registered.

---
 rtl/led_blink_pwm_driver_if.sv | 23 ++
 rtl/led_blink_pwm_driver.sv | 122 ++++++++++++
 2 files changed

// File: rtl/led_blink_pwm_driver_if.sv
// LED drive bundle: PIO pattern, blink/activity controls, brightness in; LED pins and tick out.
// master drives the controls, slave is the driver stage producing led_out/tick_out.
interface led_blink_pwm_driver_if #(
    parameter int N_LEDS   = 4,
    parameter int PWM_BITS = 4
);
    logic [N_LEDS-1:0]   led_in;
    logic [N_LEDS-1:0]   blink_mask;
    logic [N_LEDS-1:0]   activity;
    logic [PWM_BITS-1:0] brightness;
    logic [N_LEDS-1:0]   led_out;
    logic                tick_out;

    modport master (
        output led_in, blink_mask, activity, brightness,
        input  led_out, tick_out
    );

    modport slave (
        input  led_in, blink_mask, activity, brightness,
        output led_out, tick_out
    );
endinterface

// File: rtl/led_blink_pwm_driver.sv
// LED output stage: static pattern + per-LED blink + activity stretching + global PWM dimming.
// Latency: 1 cycle from led_in/blink_mask/brightness, 2 cycles from activity; no backpressure.
module led_blink_pwm_driver #(
    parameter int N_LEDS        = 4,
    parameter int PRESCALE_DIV  = 50000,
    parameter int BLINK_TICKS   = 250,
    parameter int STRETCH_TICKS = 50,
    parameter int PWM_BITS      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    led_blink_pwm_driver_if.slave   bus
);
    localparam int PRE_W = $clog2(PRESCALE_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int CNT_W = $clog2(STRETCH_TICKS + 1);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ON, GAP} act_state_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    act_state_t          state [N_LEDS];
    logic [CNT_W-1:0]    cnt   [N_LEDS];
    logic [N_LEDS-1:0]   pend;
    logic [N_LEDS-1:0]   led_q;
    logic                tick_q;

    logic                tick;
    logic                pwm_on;
    logic [N_LEDS-1:0]   raw;

    assign tick   = (pre_cnt == PRE_MAX);
    assign pwm_on = (&bus.brightness) || (pwm_cnt < bus.brightness);

    // Activity XORs onto the base so it shows on both lit and dark LEDs.
    always_comb begin
        raw = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            raw[i] = (bus.led_in[i] & (bus.blink_mask[i] ? blink_phase : 1'b1))
                   ^ (state[i] == ON);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            pwm_cnt     <= '0;
            pend        <= '0;
            led_q       <= '0;
            tick_q      <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            tick_q  <= tick;
            pwm_cnt <= pwm_cnt + 1'b1;
            led_q   <= raw & {N_LEDS{pwm_on}};

            if (tick) begin
                if (blink_cnt == BLK_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            for (int i = 0; i < N_LEDS; i++) begin
                case (state[i])
                    IDLE: begin
                        // Entry loads the window; a coincident tick is not counted.
                        if (bus.activity[i]) begin
                            state[i] <= ON;
                            cnt[i]   <= CNT_LOAD;
                        end
                    end
                    ON: begin
                        if (tick) begin
                            if (cnt[i] == CNT_ONE) begin
                                state[i] <= GAP;
                                cnt[i]   <= CNT_LOAD;
                                pend[i]  <= 1'b0;
                            end else begin
                                cnt[i] <= cnt[i] - CNT_ONE;
                            end
                        end
                    end
                    GAP: begin
                        if (bus.activity[i]) pend[i] <= 1'b1;
                        if (tick) begin
                            if (cnt[i] == CNT_ONE) begin
                                if (pend[i] || bus.activity[i]) begin
                                    state[i] <= ON;
                                    cnt[i]   <= CNT_LOAD;
                                end else begin
                                    state[i] <= IDLE;
                                end
                            end else begin
                                cnt[i] <= cnt[i] - CNT_ONE;
                            end
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign bus.led_out  = led_q;
    assign bus.tick_out = tick_q;
endmodule
